serial_subtractor: RTL and testbench

Bit-serial subtractor that computes A − B one bit per enabled clock, LSB first, with a registered borrow chain. It is the inverse-operation companion to the team's clocked one-bit adder and serves the ALU's SUB/SUBU path in area-constrained builds. Operands are captured on a start handshake; result, borrow and signed-overflow flags are held stable after a one-cycle done pulse.

---
 rtl/serial_sub_pkg.sv | 27 ++
 rtl/serial_subtractor_if.sv | 38 +++
 rtl/full_subtractor_bit.sv | 23 ++
 rtl/serial_subtractor.sv | 191 +++++++++++++++++++
 tb/tb_serial_subtractor.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - DEFAULT_WIDTH : default operand/result width
//   - sub_state_e   : control state encoding (IDLE, RUN, DONE), 2 bits
//   - signed_ovf    : two's-complement overflow rule for a subtraction,
//                     evaluated from the operand and result sign bits
// ---------------------------------------------------------------------------
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sub_state_e;

  // A - B overflows only when the operands differ in sign and the result
  // sign disagrees with the minuend sign.
  function automatic logic signed_ovf(input logic a_sign,
                                      input logic b_sign,
                                      input logic d_sign);
    return (a_sign ^ b_sign) & (d_sign ^ a_sign);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Request/result bundle of the bit-serial subtractor.
//   En       : clock enable (requester -> subtractor)
//   Start    : operation request (requester -> subtractor)
//   A, B     : minuend / subtrahend (requester -> subtractor)
//   Busy     : operation in progress (subtractor -> requester)
//   Done     : one-cycle completion pulse (subtractor -> requester)
//   Diff     : A - B mod 2^WIDTH (subtractor -> requester)
//   Borrow   : A < B unsigned (subtractor -> requester)
//   Overflow : signed overflow of A - B (subtractor -> requester)
// Modports: master = requester side, slave = subtractor side.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);

  logic             En;
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             Overflow;

  modport master (
    output En, Start, A, B,
    input  Busy, Done, Diff, Borrow, Overflow
  );

  modport slave (
    input  En, Start, A, B,
    output Busy, Done, Diff, Borrow, Overflow
  );

endinterface

// File: rtl/full_subtractor_bit.sv
// ---------------------------------------------------------------------------
// full_subtractor_bit
// Combinational one-bit full subtractor computing a - b - borrow_in.
//   a, b        : operand bits
//   borrow_in   : borrow from the less significant bit
//   d           : difference bit
//   borrow_out  : borrow into the next more significant bit
// ---------------------------------------------------------------------------
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic d,
  output logic borrow_out
);

  assign d = a ^ b ^ borrow_in;

  // Borrow when b exceeds a outright, or when the bits are equal and a
  // borrow ripples through.
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial A - B, one bit per enabled clock, LSB first, with a registered
// borrow chain. Operands are captured on an accepted Start; Diff, Borrow and
// Overflow are held after the one-cycle Done pulse until the next accepted
// Start.
//
// Ports:
//   Clk     : rising-edge clock
//   Rst_n   : asynchronous active-low reset
//   sub_if  : serial_subtractor_if.slave (En, Start, A, B in;
//             Busy, Done, Diff, Borrow, Overflow out)
//
// Build option:
//   SERIAL_SUB_SIGNED_OVF_EN : when defined, the operand sign bits are kept
//   and Overflow reports signed overflow; otherwise Overflow is tied to 0.
//
// Timing (En held high): Start accepted at edge 0, Busy high after edges
// 1..WIDTH, Done high after edge WIDTH+1. Busy and Done are registered
// images of the control state, so they trail it by one cycle. En=0 freezes
// every register, including the status outputs.
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              Clk,
  input  logic              Rst_n,
  serial_subtractor_if.slave sub_if
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  sub_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             d_bit_s;
  logic             brw_out_s;
  logic             ovf_calc_s;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             a_sign_q, a_sign_d;
  logic             b_sign_q, b_sign_d;
`endif

  // One bit slice of the subtraction, fed from the shift-register LSBs.
  full_subtractor_bit u_bit (
    .a          (a_sr_q[0]),
    .b          (b_sr_q[0]),
    .borrow_in  (brw_q),
    .d          (d_bit_s),
    .borrow_out (brw_out_s)
  );

  // Signed overflow from the captured operand signs and the finished result.
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf_calc_s = signed_ovf(a_sign_q, b_sign_q, diff_q[WIDTH-1]);
`else
  assign ovf_calc_s = 1'b0;
`endif

  // Next-state, datapath and status logic; En low holds everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    brw_d    = brw_q;
    diff_d   = diff_q;
    busy_d   = busy_q;
    done_d   = done_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
`endif

    if (sub_if.En) begin
      busy_d = (state_q == RUN);
      done_d = (state_q == DONE);

      case (state_q)
        IDLE: begin
          if (sub_if.Start) begin
            a_sr_d   = sub_if.A;
            b_sr_d   = sub_if.B;
            brw_d    = 1'b0;
            cnt_d    = {CW{1'b0}};
            diff_d   = {WIDTH{1'b0}};
            borrow_d = 1'b0;
            ovf_d    = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_sign_d = sub_if.A[WIDTH-1];
            b_sign_d = sub_if.B[WIDTH-1];
`endif
            state_d  = RUN;
          end else begin
            state_d  = IDLE;
          end
        end

        RUN: begin
          // Result bits enter at the MSB so the LSB-first stream lands in
          // place after WIDTH shifts.
          a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
          diff_d = {d_bit_s, diff_q[WIDTH-1:1]};
          brw_d  = brw_out_s;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = cnt_q;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = RUN;
          end
        end

        DONE: begin
          borrow_d = brw_q;
          ovf_d    = ovf_calc_s;
          state_d  = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      a_sr_q   <= {WIDTH{1'b0}};
      b_sr_q   <= {WIDTH{1'b0}};
      brw_q    <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      brw_q    <= brw_d;
      diff_q   <= diff_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  // Operand sign bits retained for the overflow decision.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
    end else begin
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
    end
  end
`endif

  assign sub_if.Busy     = busy_q;
  assign sub_if.Done     = done_q;
  assign sub_if.Diff     = diff_q;
  assign sub_if.Borrow   = borrow_q;
  assign sub_if.Overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Directed bench for serial_subtractor at WIDTH=8. Inputs are driven and
// outputs sampled on the falling clock edge. Expected overflow follows the
// SERIAL_SUB_SIGNED_OVF_EN build option.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W)) dut (
    .Clk    (clk),
    .Rst_n  (rst_n),
    .sub_if (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation: issue Start, optionally stall or re-pulse Start during
  // RUN, wait (bounded) for Done, then check result, latency and hold.
  task automatic run_op(input string tag,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_brw,
                        input logic exp_ovf, input int stall_at,
                        input int stall_n, input bit restart,
                        input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    sif.A     = a;
    sif.B     = b;
    sif.Start = 1'b1;
    sif.En    = 1'b1;
    @(negedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      sif.En = (lat >= stall_at && lat < stall_at + stall_n) ? 1'b0 : 1'b1;
      if (restart && lat == 2) begin
        sif.Start = 1'b1;
        sif.A     = 8'hFF;
        sif.B     = 8'h00;
      end else begin
        sif.Start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (lat == 1) check_val({tag, "_busy_first"}, 32'(sif.Busy), 32'd1);
      seen = sif.Done;
    end
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_diff"}, 32'(sif.Diff), 32'(exp_d));
    check_val({tag, "_borrow"}, 32'(sif.Borrow), 32'(exp_brw));
    check_val({tag, "_ovf"}, 32'(sif.Overflow), 32'(exp_ovf & OVF_EN));
    check_val({tag, "_busy_at_done"}, 32'(sif.Busy), 32'd0);
    sif.En    = 1'b1;
    sif.Start = 1'b0;
    @(negedge clk);
    check_val({tag, "_done_pulse"}, 32'(sif.Done), 32'd0);
    check_val({tag, "_diff_hold"}, 32'(sif.Diff), 32'(exp_d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    sif.En    = 1'b0;
    sif.Start = 1'b0;
    sif.A     = 8'h00;
    sif.B     = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_val("rst_busy", 32'(sif.Busy), 32'd0);
    check_val("rst_done", 32'(sif.Done), 32'd0);
    check_val("rst_diff", 32'(sif.Diff), 32'd0);
    check_val("rst_borrow", 32'(sif.Borrow), 32'd0);
    check_val("rst_ovf", 32'(sif.Overflow), 32'd0);

    //      tag          A      B      Diff   Brw   Ovf   stall    rs    lat
    run_op("pos_small", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 0, 1'b0, 9);
    run_op("neg_wrap",  8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0, 0, 1'b0, 9);
    run_op("ovf_neg",   8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 0, 1'b0, 9);
    run_op("ovf_pos",   8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0, 0, 1'b0, 9);
    run_op("stall3",    8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 3, 3, 1'b0, 12);
    run_op("restart",   8'h20, 8'h07, 8'h19, 1'b0, 1'b0, 0, 0, 1'b1, 9);

    // Reset in the middle of a RUN: partial result must be discarded.
    @(negedge clk);
    sif.A     = 8'h55;
    sif.B     = 8'h22;
    sif.Start = 1'b1;
    sif.En    = 1'b1;
    @(negedge clk);
    sif.Start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("midrun_busy", 32'(sif.Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 32'(sif.Busy), 32'd0);
    check_val("midrst_diff", 32'(sif.Diff), 32'd0);
    check_val("midrst_done", 32'(sif.Done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("after_rst", 8'h09, 8'h09, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0, 9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
